// File: rtl/apb_regbank_completer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_regbank_completer_pkg
// Description : Shared register-map indices, bit positions and FSM state
//               encodings for the APB register-bank completer.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_regbank_completer_pkg;

    // Register indices (byte offset = 4 * index)
    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;

    // CTRL bits
    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_CLR_DONE_BIT = 1;

    // STATUS bits
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    // Wait-state counter width (WAIT_STATES range 0..15)
    localparam int WAIT_CNT_W = 4;

    // Transfer FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

endpackage
`default_nettype wire

// File: rtl/apb_regbank_completer_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_timer
// Description : Loadable down-counter with zero flag; holds the number of
//               wait states still to be inserted in the ACCESS phase.
// Ports       : clk, rst (async, active-high)
//               i_load / i_load_val - load the counter
//               i_dec               - decrement (saturates at zero)
//               o_count / o_zero    - current count and zero flag
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/apb_regbank_completer.sv
`default_nettype none
// ============================================================================
// Module      : apb_regbank_completer
// Description : APB4 completer terminating at a register bank with CTRL,
//               STATUS and DATA registers, byte-strobe merging, programmable
//               wait states, PSLVERR on illegal accesses and a start/done/busy
//               handshake towards a crypto core.
// Ports       : clk, rst (async, active-high)
//               paddr, pprot, psel, penable, pwrite, pwdata, pstrb - APB in
//               pready, pslverr, prdata                            - APB out
//               regs_out - flattened bank contents (index 0 at LSBs)
//               start    - one-cycle pulse after a CTRL.START write
//               busy_in, done_in - core status inputs
// Config      : APB_PPROT_CHECK_EN - when defined, unprivileged (pprot[0]=0)
//               accesses to CTRL are rejected with pslverr.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_regbank_completer #(
    parameter int APB_ADDR_WIDTH   = 32,
    parameter int APB_DATA_WIDTH   = 32,
    parameter int APB_STROBE_WIDTH = 4,
    parameter int NUM_REGS         = 8,
    parameter int WAIT_STATES      = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [APB_ADDR_WIDTH-1:0]          paddr,
    input  logic [2:0]                         pprot,
    input  logic                               psel,
    input  logic                               penable,
    input  logic                               pwrite,
    input  logic [APB_DATA_WIDTH-1:0]          pwdata,
    input  logic [APB_STROBE_WIDTH-1:0]        pstrb,
    output logic                               pready,
    output logic                               pslverr,
    output logic [APB_DATA_WIDTH-1:0]          prdata,
    output logic [NUM_REGS*APB_DATA_WIDTH-1:0] regs_out,
    output logic                               start,
    input  logic                               busy_in,
    input  logic                               done_in
);

    import apb_regbank_completer_pkg::*;

    // One index bit beyond what NUM_REGS needs, so the first offset past the
    // bank (e.g. 0x20 for 8 registers) decodes as out of range instead of
    // aliasing back onto CTRL.
    localparam int c_idx_w = $clog2(NUM_REGS) + 1;

    localparam logic [WAIT_CNT_W-1:0]     c_wait_load = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [APB_DATA_WIDTH-1:0] c_ctrl_action_mask =
        (APB_DATA_WIDTH'(1) << CTRL_START_BIT) | (APB_DATA_WIDTH'(1) << CTRL_CLR_DONE_BIT);

    // ------------------------------------------------------------------------
    // Byte-lane merge of write data over the current register value
    // ------------------------------------------------------------------------
    function automatic logic [APB_DATA_WIDTH-1:0] strobe_merge(
        input logic [APB_DATA_WIDTH-1:0]   old_val,
        input logic [APB_DATA_WIDTH-1:0]   new_val,
        input logic [APB_STROBE_WIDTH-1:0] strb
    );
        logic [APB_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < APB_STROBE_WIDTH; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic                      r_pready;
    logic                      r_pslverr;
    logic [APB_DATA_WIDTH-1:0] r_prdata;
    logic                      r_start;
    logic                      r_done;

    logic                      w_load;
    logic                      w_dec;
    logic [WAIT_CNT_W-1:0]     w_count;
    logic                      w_zero;
    logic                      w_pready_next;

    logic [c_idx_w-1:0]        w_idx;
    logic                      w_in_range;
    logic                      w_is_ctrl;
    logic                      w_is_status;
    logic                      w_prot_err;
    logic                      w_err;
    logic                      w_commit;
    logic                      w_ctrl_wr;
    logic                      w_start_next;
    logic                      w_clr_done;
    logic [APB_DATA_WIDTH-1:0] w_status;
    logic [APB_DATA_WIDTH-1:0] w_rd_value;
    logic [APB_DATA_WIDTH-1:0] w_reg_view [NUM_REGS];
    logic                      w_unused;

    // ------------------------------------------------------------------------
    // Address decode and error classification
    // ------------------------------------------------------------------------
    assign w_idx       = paddr[c_idx_w+1:2];
    assign w_in_range  = (32'(w_idx) < NUM_REGS);
    assign w_is_ctrl   = (w_idx == c_idx_w'(REG_CTRL));
    assign w_is_status = (w_idx == c_idx_w'(REG_STATUS));

`ifdef APB_PPROT_CHECK_EN
    assign w_prot_err = w_is_ctrl & ~pprot[0];
    assign w_unused   = ^{paddr[APB_ADDR_WIDTH-1:c_idx_w+2], pprot[2:1]};
`else
    assign w_prot_err = 1'b0;
    assign w_unused   = ^{paddr[APB_ADDR_WIDTH-1:c_idx_w+2], pprot};
`endif

    assign w_err = ~w_in_range | (paddr[1:0] != 2'b00) | (pwrite & w_is_status) | w_prot_err;

    // The completion cycle is the ACCESS cycle with pready high; writes land
    // at its closing edge.
    assign w_commit     = (r_state == ST_ACCESS) & r_pready & psel & penable & pwrite & ~w_err;
    assign w_ctrl_wr    = w_commit & w_is_ctrl & pstrb[0];
    assign w_start_next = w_ctrl_wr & pwdata[CTRL_START_BIT];
    assign w_clr_done   = w_ctrl_wr & pwdata[CTRL_CLR_DONE_BIT];

    // ------------------------------------------------------------------------
    // Wait-state timer
    // ------------------------------------------------------------------------
    apb_wait_timer #(
        .CNT_W (WAIT_CNT_W)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (c_wait_load),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    // ------------------------------------------------------------------------
    // Transfer FSM: next state and timer control
    // ------------------------------------------------------------------------
    // pready is a flop, so it is set one cycle ahead: from SETUP when there
    // are no wait states, otherwise from the ACCESS cycle whose count is 1.
    // It is therefore high exactly in the ACCESS cycle where the count is 0.
    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_dec         = 1'b0;
        w_pready_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (!psel) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_load        = 1'b1;
                    w_next_state  = ST_ACCESS;
                    w_pready_next = penable && (WAIT_STATES == 0);
                end
            end
            ST_ACCESS: begin
                if (!psel || r_pready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_dec         = ~w_zero;
                    w_pready_next = penable && (w_zero || (w_count == WAIT_CNT_W'(1)));
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Register views, bank storage and flattened output
    // ------------------------------------------------------------------------
    always_comb begin
        w_status                  = '0;
        w_status[STATUS_BUSY_BIT] = busy_in;
        w_status[STATUS_DONE_BIT] = r_done;
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
            if (g == REG_STATUS) begin : g_status
                assign w_reg_view[g] = w_status;
            end else begin : g_stored
                logic [APB_DATA_WIDTH-1:0] r_value;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_value <= '0;
                    end else if (w_commit && (w_idx == c_idx_w'(g))) begin
                        // CTRL action bits are pulses and never hold state
                        r_value <= (g == REG_CTRL)
                                 ? (strobe_merge(r_value, pwdata, pstrb) & ~c_ctrl_action_mask)
                                 : strobe_merge(r_value, pwdata, pstrb);
                    end
                end
                assign w_reg_view[g] = r_value;
            end
            assign regs_out[g*APB_DATA_WIDTH +: APB_DATA_WIDTH] = w_reg_view[g];
        end
    endgenerate

    always_comb begin
        w_rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == c_idx_w'(i)) begin
                w_rd_value = w_reg_view[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_start   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pready  <= w_pready_next;
            r_pslverr <= w_pready_next & w_err;
            r_prdata  <= (w_pready_next && !w_err && !pwrite) ? w_rd_value : '0;
            r_start   <= w_start_next;
            // A done pulse in the same cycle as CLR_DONE takes priority
            if (done_in) begin
                r_done <= 1'b1;
            end else if (w_clr_done) begin
                r_done <= 1'b0;
            end
        end
    end

    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign prdata  = r_prdata;
    assign start   = r_start;

endmodule
`default_nettype wire

// File: tb/tb_apb_regbank_completer.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_regbank_completer
// Description : Self-checking bench for apb_regbank_completer. Two instances
//               (0 and 3 wait states) are driven through directed and random
//               APB transfers and compared against a register-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_regbank_completer;

    import apb_regbank_completer_pkg::*;

    localparam int DW = 32;
    localparam int NR = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       paddr;
    logic [2:0]        pprot;
    logic [1:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic              busy_in;
    logic              done_in;
    logic [1:0]        pready;
    logic [1:0]        pslverr;
    logic [1:0]        start;
    logic [31:0]       prdata   [2];
    logic [NR*DW-1:0]  regs_out [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_bank [2][NR];
    logic        m_done [2];

    always #5 clk = ~clk;

    apb_regbank_completer #(
        .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(DW), .APB_STROBE_WIDTH(4),
        .NUM_REGS(NR), .WAIT_STATES(0)
    ) dut_ws0 (
        .clk(clk), .rst(rst), .paddr(paddr), .pprot(pprot), .psel(psel[0]),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready[0]), .pslverr(pslverr[0]), .prdata(prdata[0]),
        .regs_out(regs_out[0]), .start(start[0]), .busy_in(busy_in), .done_in(done_in)
    );

    apb_regbank_completer #(
        .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(DW), .APB_STROBE_WIDTH(4),
        .NUM_REGS(NR), .WAIT_STATES(3)
    ) dut_ws3 (
        .clk(clk), .rst(rst), .paddr(paddr), .pprot(pprot), .psel(psel[1]),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready[1]), .pslverr(pslverr[1]), .prdata(prdata[1]),
        .regs_out(regs_out[1]), .start(start[1]), .busy_in(busy_in), .done_in(done_in)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int ws_of(input int w);
        return (w == 0) ? 0 : 3;
    endfunction

    function automatic void m_reset();
        for (int w = 0; w < 2; w++) begin
            m_done[w] = 1'b0;
            for (int i = 0; i < NR; i++) m_bank[w][i] = 32'h0;
        end
    endfunction

    // What a register reads as, from the register map alone
    function automatic logic [31:0] m_view(input int w, input int idx);
        logic [31:0] v;
        if (idx == REG_STATUS) begin
            v = 32'h0;
            v[STATUS_BUSY_BIT] = busy_in;
            v[STATUS_DONE_BIT] = m_done[w];
        end else begin
            v = m_bank[w][idx];
        end
        return v;
    endfunction

    function automatic bit m_err(input logic [31:0] addr, input bit wr, input logic [2:0] prot);
        int idx;
        bit e;
        idx = int'(addr >> 2);
        e = (addr[1:0] != 2'b00) || (idx >= NR) || (wr && idx == REG_STATUS);
`ifdef APB_PPROT_CHECK_EN
        if (idx == REG_CTRL && !prot[0]) e = 1'b1;
`else
        if (prot == 3'b111 && 1'b0) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic check_bank(input int w, input string tag);
        for (int i = 0; i < NR; i++)
            check_val($sformatf("%s regs_out[%0d] dut%0d", tag, i, w),
                      regs_out[w][i*DW +: DW], m_view(w, i));
    endtask

    // One complete APB transfer on instance w, checked against the model.
    task automatic apb_xfer(input int w, input logic [31:0] addr, input bit wr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [2:0] prot, input bit done_at_end, input string tag);
        int          lat;
        int          idx;
        bit          exp_err;
        bit          exp_start;
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        logic        got_err;
        logic [31:0] nv;

        idx       = int'(addr >> 2);
        exp_err   = m_err(addr, wr, prot);
        exp_rd    = (!wr && !exp_err) ? m_view(w, idx) : 32'h0;
        exp_start = wr && !exp_err && (idx == REG_CTRL) && strb[0] && wdata[CTRL_START_BIT];

        @(posedge clk); #1;
        paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; pprot = prot;
        psel[w] = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 1;
        while (pready[w] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got_rd  = prdata[w];
        got_err = pslverr[w];
        if (done_at_end) done_in = 1'b1;
        check_val({tag, " latency"}, lat, 2 + ws_of(w));
        check_val({tag, " pslverr"}, {31'h0, got_err}, {31'h0, exp_err});
        check_val({tag, " prdata"}, got_rd, exp_rd);

        @(posedge clk); #1;
        psel = 2'b00; penable = 1'b0; done_in = 1'b0;

        if (wr && !exp_err) begin
            nv = m_bank[w][idx];
            for (int b = 0; b < 4; b++)
                if (strb[b]) nv[b*8 +: 8] = wdata[b*8 +: 8];
            if (idx == REG_CTRL) begin
                if (strb[0] && wdata[CTRL_CLR_DONE_BIT]) m_done[w] = 1'b0;
                nv[CTRL_START_BIT]    = 1'b0;
                nv[CTRL_CLR_DONE_BIT] = 1'b0;
            end
            m_bank[w][idx] = nv;
        end
        if (done_at_end) begin
            m_done[0] = 1'b1;
            m_done[1] = 1'b1;
        end

        check_val({tag, " pready one cycle"}, {31'h0, pready[w]}, 32'h0);
        check_val({tag, " start"}, {31'h0, start[w]}, {31'h0, exp_start});
        check_bank(w, tag);
        @(posedge clk); #1;
        check_val({tag, " start cleared"}, {31'h0, start[w]}, 32'h0);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1;
        done_in = 1'b1;
        @(posedge clk); #1;
        done_in = 1'b0;
        m_done[0] = 1'b1;
        m_done[1] = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        bit          wr;

        rst = 1'b1; paddr = '0; pprot = '0; psel = '0; penable = 1'b0;
        pwrite = 1'b0; pwdata = '0; pstrb = '0; busy_in = 1'b0; done_in = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("reset pready%0d", k),  {31'h0, pready[k]},  32'h0);
            check_val($sformatf("reset pslverr%0d", k), {31'h0, pslverr[k]}, 32'h0);
            check_val($sformatf("reset prdata%0d", k),  prdata[k], 32'h0);
            check_val($sformatf("reset start%0d", k),   {31'h0, start[k]},   32'h0);
            check_bank(k, "reset");
        end
        rst = 1'b0;

        // Full-word write and readback at both wait-state settings
        apb_xfer(0, 32'h08, 1, 32'hA5A5_1234, 4'hF, 3'b001, 0, "ws0 wr 08");
        apb_xfer(0, 32'h08, 0, 32'h0,         4'h0, 3'b001, 0, "ws0 rd 08");
        apb_xfer(1, 32'h08, 1, 32'hA5A5_1234, 4'hF, 3'b001, 0, "ws3 wr 08");
        apb_xfer(1, 32'h08, 0, 32'h0,         4'h0, 3'b001, 0, "ws3 rd 08");

        // Partial-strobe merge and empty-strobe no-op
        apb_xfer(0, 32'h0C, 1, 32'h1122_3344, 4'hF,    3'b001, 0, "wr 0C full");
        apb_xfer(0, 32'h0C, 1, 32'h0000_00FF, 4'b0001, 3'b001, 0, "wr 0C lane0");
        apb_xfer(0, 32'h0C, 1, 32'hDEAD_BEEF, 4'b0000, 3'b001, 0, "wr 0C nostrb");
        apb_xfer(0, 32'h0C, 0, 32'h0,         4'h0,    3'b001, 0, "rd 0C");

        // Illegal accesses
        apb_xfer(0, 32'h20, 0, 32'h0,         4'h0, 3'b001, 0, "rd 20 range");
        apb_xfer(0, 32'h04, 1, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, "wr 04 status");
        apb_xfer(0, 32'h09, 1, 32'h5555_5555, 4'hF, 3'b001, 0, "wr 09 misalign");
        apb_xfer(1, 32'h3C, 1, 32'h5555_5555, 4'hF, 3'b001, 0, "wr 3C range");

        // Start pulse, sticky done, clear, and set-wins collision
        apb_xfer(0, 32'h00, 1, 32'h0000_0001, 4'hF, 3'b001, 0, "ctrl start");
        pulse_done();
        apb_xfer(0, 32'h04, 0, 32'h0,         4'h0, 3'b001, 0, "status done");
        apb_xfer(0, 32'h00, 1, 32'h0000_0002, 4'hF, 3'b001, 0, "ctrl clr");
        apb_xfer(0, 32'h04, 0, 32'h0,         4'h0, 3'b001, 0, "status cleared");
        apb_xfer(0, 32'h00, 1, 32'hF0F0_F0F2, 4'hF, 3'b001, 1, "ctrl clr+done");
        apb_xfer(0, 32'h04, 0, 32'h0,         4'h0, 3'b001, 0, "status set wins");
        apb_xfer(0, 32'h00, 0, 32'h0,         4'h0, 3'b001, 0, "ctrl readback");
        busy_in = 1'b1;
        apb_xfer(1, 32'h04, 0, 32'h0,         4'h0, 3'b001, 0, "status busy");
        busy_in = 1'b0;

        // Unprivileged CTRL access
        apb_xfer(0, 32'h00, 1, 32'h0000_0001, 4'hF, 3'b000, 0, "ctrl unpriv wr");
        apb_xfer(1, 32'h00, 0, 32'h0,         4'h0, 3'b000, 0, "ctrl unpriv rd");

        // Reset in the middle of a waited ACCESS phase
        @(posedge clk); #1;
        paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF; pprot = 3'b001;
        psel[1] = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check_val("midrst pready", {31'h0, pready[1]}, 32'h0);
        check_val("midrst state", {30'h0, dut_ws3.r_state}, {30'h0, ST_IDLE});
        check_bank(1, "midrst");
        check_bank(0, "midrst other");
        @(posedge clk); #1;
        psel = 2'b00; penable = 1'b0;
        rst = 1'b0;
        apb_xfer(1, 32'h10, 1, 32'hCAFE_F00D, 4'hF, 3'b001, 0, "retry wr 10");
        apb_xfer(1, 32'h10, 0, 32'h0,         4'h0, 3'b001, 0, "retry rd 10");

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            w     = int'($urandom_range(0, 1));
            addr  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            strb  = 4'($urandom_range(0, 15));
            prot  = 3'($urandom_range(0, 7));
            busy_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) pulse_done();
            apb_xfer(w, addr, wr, wdata, strb, prot, ($urandom_range(0, 7) == 0),
                     $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
